// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle for the PS/2 set-2 scancode decoder.
// master drives bytes and consumes events; slave is the decoder.
interface ps2_key_decoder_if #(
   parameter int CNT_W = 8
);
   logic             code_valid;
   logic [7:0]       code_in;
   logic             key_valid;
   logic             key_ready;
   logic [7:0]       key_ascii;
   logic [7:0]       key_scan;
   logic             key_ext;
   logic             key_down;
   logic [7:0]       held_scan;
   logic             shift;
   logic [CNT_W-1:0] press_count;
   logic             overflow;

   modport master (
      output code_valid, code_in, key_ready,
      input  key_valid, key_ascii, key_scan, key_ext,
      input  key_down, held_scan, shift, press_count, overflow
   );

   modport slave (
      input  code_valid, code_in, key_ready,
      output key_valid, key_ascii, key_scan, key_ext,
      output key_down, held_scan, shift, press_count, overflow
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: E0/F0 prefix tracking, shift state,
// held-key status, press counter and a FIFO of decoded key presses.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input logic              clk,
   input logic              rst,
   ps2_key_decoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 17;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BRK,
      S_EXT,
      S_EXT_BRK
   } state_t;

   state_t           state_q, state_d;
   logic             lsh_q, lsh_d;
   logic             rsh_q, rsh_d;
   logic             key_down_q, key_down_d;
   logic [7:0]       held_scan_q, held_scan_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             overflow_q, overflow_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [EW-1:0]    mem_d [FIFO_DEPTH];

   logic [7:0]    code;
   logic          is_e0, is_f0;
   logic          ev_make, ev_brk, ev_ext;
   logic          is_shift, is_rpt;
   logic          push_req, do_push, pop;
   logic          empty, full;
   logic [7:0]    ascii;
   logic [EW-1:0] entry, head;

   function automatic logic [7:0] ascii_of(
      input logic [7:0] sc,
      input logic       sh
   );
      logic [7:0] a;
      case (sc)
         8'h1C: a = 8'h61;
         8'h32: a = 8'h62;
         8'h21: a = 8'h63;
         8'h23: a = 8'h64;
         8'h24: a = 8'h65;
         8'h2B: a = 8'h66;
         8'h34: a = 8'h67;
         8'h33: a = 8'h68;
         8'h43: a = 8'h69;
         8'h3B: a = 8'h6A;
         8'h42: a = 8'h6B;
         8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;
         8'h31: a = 8'h6E;
         8'h44: a = 8'h6F;
         8'h4D: a = 8'h70;
         8'h15: a = 8'h71;
         8'h2D: a = 8'h72;
         8'h1B: a = 8'h73;
         8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;
         8'h2A: a = 8'h76;
         8'h1D: a = 8'h77;
         8'h22: a = 8'h78;
         8'h35: a = 8'h79;
         8'h1A: a = 8'h7A;
         8'h16: a = 8'h31;
         8'h1E: a = 8'h32;
         8'h26: a = 8'h33;
         8'h25: a = 8'h34;
         8'h2E: a = 8'h35;
         8'h36: a = 8'h36;
         8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;
         8'h46: a = 8'h39;
         8'h45: a = 8'h30;
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         8'h66: a = 8'h08;
         8'h0D: a = 8'h09;
         8'h76: a = 8'h1B;
         8'h41: a = 8'h2C;
         8'h49: a = 8'h2E;
         8'h4A: a = 8'h2F;
         8'h4C: a = 8'h3B;
         8'h52: a = 8'h27;
         8'h54: a = 8'h5B;
         8'h5B: a = 8'h5D;
         8'h4E: a = 8'h2D;
         8'h55: a = 8'h3D;
         default: a = 8'h00;
      endcase
      // only the alphabet has a shifted form
      if (sh && a >= 8'h61 && a <= 8'h7A) begin
         a = a - 8'h20;
      end
      return a;
   endfunction

   assign code  = bus.code_in;
   assign is_e0 = (code == 8'hE0);
   assign is_f0 = (code == 8'hF0);

   always_comb begin
      state_d = state_q;
      ev_make = 1'b0;
      ev_brk  = 1'b0;
      ev_ext  = 1'b0;
      if (bus.code_valid) begin
         unique case (state_q)
            S_IDLE: begin
               if (is_e0) begin
                  state_d = S_EXT;
               end else if (is_f0) begin
                  state_d = S_BRK;
               end else begin
                  ev_make = 1'b1;
               end
            end
            S_BRK: begin
               if (!is_e0 && !is_f0) begin
                  ev_brk  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_EXT: begin
               if (is_f0) begin
                  state_d = S_EXT_BRK;
               end else if (!is_e0) begin
                  ev_make = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (!is_e0 && !is_f0) begin
                  ev_brk  = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign is_shift = !ev_ext && (code == 8'h12 || code == 8'h59);
   assign is_rpt   = key_down_q && (held_scan_q == code);
   assign push_req = ev_make && !is_shift;
   assign pop      = !empty && bus.key_ready;
   assign do_push  = push_req && (!full || pop);

   // shift seen here is the state before this byte takes effect
   assign ascii = ev_ext ? 8'h00 : ascii_of(code, lsh_q | rsh_q);
   assign entry = {ev_ext, code, ascii};

   always_comb begin
      lsh_d         = lsh_q;
      rsh_d         = rsh_q;
      key_down_d    = key_down_q;
      held_scan_d   = held_scan_q;
      press_count_d = press_count_q;
      overflow_d    = overflow_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      mem_d         = mem_q;
      if (is_shift && (ev_make || ev_brk)) begin
         if (code == 8'h12) begin
            lsh_d = ev_make;
         end else begin
            rsh_d = ev_make;
         end
      end
      if (push_req) begin
         held_scan_d = code;
         key_down_d  = 1'b1;
         if (!is_rpt) begin
            press_count_d = press_count_q + CNT_W'(1);
         end
         if (full && !pop) begin
            overflow_d = 1'b1;
         end
      end
      if (ev_brk && !is_shift && code == held_scan_q) begin
         key_down_d = 1'b0;
      end
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = entry;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         lsh_q         <= 1'b0;
         rsh_q         <= 1'b0;
         key_down_q    <= 1'b0;
         held_scan_q   <= 8'h00;
         press_count_q <= '0;
         overflow_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         lsh_q         <= lsh_d;
         rsh_q         <= rsh_d;
         key_down_q    <= key_down_d;
         held_scan_q   <= held_scan_d;
         press_count_q <= press_count_d;
         overflow_q    <= overflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         mem_q         <= mem_d;
      end
   end

   // head fields read as zero while the queue is empty
   assign head            = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign bus.key_valid   = !empty;
   assign bus.key_ext     = head[16];
   assign bus.key_scan    = head[15:8];
   assign bus.key_ascii   = head[7:0];
   assign bus.key_down    = key_down_q;
   assign bus.held_scan   = held_scan_q;
   assign bus.shift       = lsh_q | rsh_q;
   assign bus.press_count = press_count_q;
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a prefix/shift/queue model
// predicts key events; a negedge monitor checks every pop and status.
module tb_ps2_key_decoder;
   localparam int DEPTH = 8;
   localparam int CW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_key_decoder_if #(.CNT_W(CW)) bus ();

   ps2_key_decoder #(
      .FIFO_DEPTH(DEPTH),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ext;
      logic [7:0] scan;
      logic [7:0] ascii;
   } ev_t;

   ev_t sb[$];

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] letter_sc [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] misc_sc [14] = '{
      8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h41, 8'h49,
      8'h4A, 8'h4C, 8'h52, 8'h54, 8'h5B, 8'h4E, 8'h55};
   logic [7:0] misc_ch [14] = '{
      8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h2C, 8'h2E,
      8'h2F, 8'h3B, 8'h27, 8'h5B, 8'h5D, 8'h2D, 8'h3D};

   bit          m_ext, m_brk, m_lsh, m_rsh, m_down, m_ovf;
   logic [7:0]  m_held;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] sc,
                                            input bit ext, input bit sh);
      if (ext) return 8'h00;
      for (int i = 0; i < 26; i++)
         if (letter_sc[i] == sc) return (sh ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (digit_sc[i] == sc) return 8'h30 + 8'(i);
      for (int i = 0; i < 14; i++)
         if (misc_sc[i] == sc) return misc_ch[i];
      return 8'h00;
   endfunction

   task automatic model_event(input bit make, input bit ext, input logic [7:0] b);
      bit sh_key;
      ev_t e;
      sh_key = !ext && (b == 8'h12 || b == 8'h59);
      if (sh_key) begin
         if (b == 8'h12) m_lsh = make;
         else m_rsh = make;
      end else if (make) begin
         e.ext   = ext;
         e.scan  = b;
         e.ascii = ref_ascii(b, ext, m_lsh | m_rsh);
         if (sb.size() < DEPTH) sb.push_back(e);
         else m_ovf = 1'b1;
         if (!(m_down && m_held == b)) m_cnt = m_cnt + 1'b1;
         m_held = b;
         m_down = 1'b1;
      end else if (b == m_held) begin
         m_down = 1'b0;
      end
   endtask

   // reference model: queue occupancy seen here already reflects the
   // pop the monitor recorded on the preceding negedge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0;
         m_down = 0; m_ovf = 0; m_held = 8'h00; m_cnt = '0;
         sb.delete();
      end else if (bus.code_valid) begin
         if (bus.code_in == 8'hE0) begin
            if (!m_brk) m_ext = 1'b1;
         end else if (bus.code_in == 8'hF0) begin
            m_brk = 1'b1;
         end else begin
            model_event(!m_brk, m_ext, bus.code_in);
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         chk("rst_key_valid", 32'(bus.key_valid), 0);
         chk("rst_key_ascii", 32'(bus.key_ascii), 0);
         chk("rst_key_scan", 32'(bus.key_scan), 0);
         chk("rst_key_ext", 32'(bus.key_ext), 0);
         chk("rst_key_down", 32'(bus.key_down), 0);
         chk("rst_held_scan", 32'(bus.held_scan), 0);
         chk("rst_shift", 32'(bus.shift), 0);
         chk("rst_press_count", 32'(bus.press_count), 0);
         chk("rst_overflow", 32'(bus.overflow), 0);
      end else begin
         chk("key_valid", 32'(bus.key_valid), 32'(sb.size() != 0));
         chk("shift", 32'(bus.shift), 32'(m_lsh | m_rsh));
         chk("key_down", 32'(bus.key_down), 32'(m_down));
         chk("held_scan", 32'(bus.held_scan), 32'(m_held));
         chk("press_count", 32'(bus.press_count), 32'(m_cnt));
         chk("overflow", 32'(bus.overflow), 32'(m_ovf));
         if (bus.key_valid && bus.key_ready) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 32'(bus.key_valid), 0);
            end else begin
               e = sb.pop_front();
               chk("ev_ascii", 32'(bus.key_ascii), 32'(e.ascii));
               chk("ev_scan", 32'(bus.key_scan), 32'(e.scan));
               chk("ev_ext", 32'(bus.key_ext), 32'(e.ext));
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bus.code_valid = 1'b1;
      bus.code_in    = b;
      @(posedge clk); #1;
      bus.code_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      bus.code_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int mode;
      int r;
      logic [7:0] last_b;
      bus.code_valid = 1'b0;
      bus.code_in    = 8'h00;
      bus.key_ready  = 1'b0;
      idle(2);
      rst = 1'b0;

      // single make, then pop
      do_reset();
      bus.key_ready = 1'b0;
      send(8'h1C);
      @(negedge clk);
      chk("t1_valid", 32'(bus.key_valid), 1);
      chk("t1_ascii", 32'(bus.key_ascii), 32'h61);
      chk("t1_scan", 32'(bus.key_scan), 32'h1C);
      chk("t1_ext", 32'(bus.key_ext), 0);
      chk("t1_count", 32'(bus.press_count), 1);
      chk("t1_down", 32'(bus.key_down), 1);
      @(posedge clk); #1 bus.key_ready = 1'b1;
      @(posedge clk); #1 bus.key_ready = 1'b0;
      @(negedge clk);
      chk("t1_popped", 32'(bus.key_valid), 0);
      @(posedge clk); #1;

      // shifted and unshifted letter
      do_reset();
      bus.key_ready = 1'b1;
      send(8'h12); send(8'h1C);
      @(negedge clk);
      chk("t2_shift_on", 32'(bus.shift), 1);
      @(posedge clk); #1;
      send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      @(negedge clk);
      chk("t2_shift_off", 32'(bus.shift), 0);
      @(posedge clk); #1;
      send(8'h1C);
      idle(3);
      @(negedge clk);
      chk("t2_count", 32'(bus.press_count), 2);
      @(posedge clk); #1;

      // typematic repeat
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      idle(3);
      @(negedge clk);
      chk("t3_count", 32'(bus.press_count), 1);
      chk("t3_down", 32'(bus.key_down), 0);
      @(posedge clk); #1;

      // extended make/break then plain space
      do_reset();
      bus.key_ready = 1'b0;
      send(8'hE0); send(8'h75);
      @(negedge clk);
      chk("t4_ext", 32'(bus.key_ext), 1);
      chk("t4_scan", 32'(bus.key_scan), 32'h75);
      chk("t4_ascii", 32'(bus.key_ascii), 0);
      @(posedge clk); #1;
      bus.key_ready = 1'b1;
      send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
      @(negedge clk);
      chk("t4_space", 32'(bus.key_ascii), 32'h20);
      @(posedge clk); #1;
      idle(3);

      // fill, push+pop when full, then drop
      do_reset();
      bus.key_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(letter_sc[i]);
      @(negedge clk);
      chk("t5_full_ovf", 32'(bus.overflow), 0);
      @(posedge clk); #1;
      bus.key_ready = 1'b1;
      send(letter_sc[DEPTH]);
      bus.key_ready = 1'b0;
      @(negedge clk);
      chk("t5_pushpop_ovf", 32'(bus.overflow), 0);
      @(posedge clk); #1;
      send(letter_sc[DEPTH+1]);
      @(negedge clk);
      chk("t5_drop_ovf", 32'(bus.overflow), 1);
      @(posedge clk); #1;
      bus.key_ready = 1'b1;
      idle(DEPTH + 2);
      @(negedge clk);
      chk("t5_drained", 32'(bus.key_valid), 0);
      chk("t5_ovf_sticky", 32'(bus.overflow), 1);
      @(posedge clk); #1;

      // reset in the middle of a prefix
      do_reset();
      send(8'hE0); send(8'hF0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.key_ready = 1'b0;
      send(8'h1C);
      @(negedge clk);
      chk("t6_ascii", 32'(bus.key_ascii), 32'h61);
      chk("t6_ext", 32'(bus.key_ext), 0);
      @(posedge clk); #1;

      // randomized stream
      do_reset();
      mode = 1;
      last_b = 8'h1C;
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) mode = $urandom_range(0, 3);
         bus.key_ready = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         bus.code_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 99);
         if (r < 10) bus.code_in = 8'hE0;
         else if (r < 22) bus.code_in = 8'hF0;
         else if (r < 30) bus.code_in = r[0] ? 8'h12 : 8'h59;
         else if (r < 65) bus.code_in = letter_sc[$urandom_range(0, 25)];
         else if (r < 72) bus.code_in = digit_sc[$urandom_range(0, 9)];
         else if (r < 80) bus.code_in = misc_sc[$urandom_range(0, 13)];
         else if (r < 90) bus.code_in = last_b;
         else bus.code_in = 8'($urandom_range(0, 255));
         if (bus.code_valid && bus.code_in != 8'hE0 && bus.code_in != 8'hF0)
            last_b = bus.code_in;
         @(posedge clk); #1;
      end
      bus.code_valid = 1'b0;
      bus.key_ready  = 1'b1;
      for (int i = 0; i < DEPTH + 4 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("final_drain", 32'(sb.size()), 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
